// File: rtl/cond_logic_if.sv
// Decoder/ALU-side bundle for the conditional-execution stage.
// Latency: outputs are combinational on the inputs and stored flags.
// Backpressure: Stall holds the instruction and zeroes the write enables.
interface cond_logic_if;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       Stall;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        input  PCSrc, RegWrite, MemWrite, CondEx, Flags
    );

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, Stall,
        output PCSrc, RegWrite, MemWrite, CondEx, Flags
    );
endinterface

// File: rtl/cond_logic.sv
// NZCV flag register plus condition check gating PC/reg/mem writes; COND_NV_AL_EN makes Cond=1111 AL.
// Latency: gated outputs zero-cycle; new flags visible to the next instruction.
// Backpressure: Stall freezes flags and forces PCSrc/RegWrite/MemWrite low.
module cond_logic #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic         CLK,
    input  logic         RESET,
    cond_logic_if.slave  bus
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ex;
    logic       retire;
    logic       n_flag;
    logic       z_flag;
    logic       c_flag;
    logic       v_flag;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    // Decode uses only the stored flags so an instruction never sees its own ALU result.
    always_comb begin
        cond_ex = 1'b0;
        case (bus.Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
`ifdef COND_NV_AL_EN
            4'b1111: cond_ex = 1'b1;
`else
            4'b1111: cond_ex = 1'b0;
`endif
            default: cond_ex = 1'b0;
        endcase
    end

    assign retire = cond_ex & ~bus.Stall;

    // N,Z and C,V groups load independently so logical ops can preserve C,V.
    always_comb begin
        flags_d = flags_q;
        if (retire && bus.FlagW[1]) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
        end
        if (retire && bus.FlagW[0]) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            flags_q <= FLAGS_RESET;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign bus.CondEx   = cond_ex;
    assign bus.PCSrc    = bus.PCS  & retire;
    assign bus.RegWrite = bus.RegW & retire & ~bus.NoWrite;
    assign bus.MemWrite = bus.MemW & retire;
    assign bus.Flags    = flags_q;

endmodule

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, flag load, condition table, gating, stall, NV.
module tb_cond_logic;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    logic nv_exp;

    cond_logic_if bus ();

    cond_logic dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cond, input logic [3:0] alu, input logic [1:0] fw,
                         input logic pcs, input logic regw, input logic memw,
                         input logic nw, input logic st);
        bus.Cond     = cond;
        bus.ALUFlags = alu;
        bus.FlagW    = fw;
        bus.PCS      = pcs;
        bus.RegW     = regw;
        bus.MemW     = memw;
        bus.NoWrite  = nw;
        bus.Stall    = st;
        #1;
    endtask

    task automatic load_flags(input logic [3:0] f);
        drive(4'hE, f, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(4'hE, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.Flags !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b expected 0000", bus.Flags);
        end
        drive(4'h0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.CondEx !== 1'b0 || bus.RegWrite !== 1'b0) begin
            n_err++; $display("FAIL reset_eq: got condex=%b regwrite=%b expected 0 0", bus.CondEx, bus.RegWrite);
        end
        // Outputs during reset follow the flags being reset; reset beats Stall.
        load_flags(4'b1111);
        rst = 1'b1;
        drive(4'h0, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++; $display("FAIL reset_outputs_live: got regwrite=%b expected 1", bus.RegWrite);
        end
        drive(4'h0, 4'b0101, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.Flags !== 4'b0000) begin
            n_err++; $display("FAIL reset_wins: got %b expected 0000", bus.Flags);
        end
    endtask

    task automatic test_flag_load_eq();
        load_flags(4'b0100);
        n_cmp++;
        if (bus.Flags !== 4'b0100) begin
            n_err++; $display("FAIL load_flags: got %b expected 0100", bus.Flags);
        end
        drive(4'h0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b1 || bus.MemWrite !== 1'b1) begin
            n_err++; $display("FAIL eq_pass: got reg=%b mem=%b expected 1 1", bus.RegWrite, bus.MemWrite);
        end
        drive(4'h1, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
            n_err++; $display("FAIL ne_fail: got reg=%b mem=%b expected 0 0", bus.RegWrite, bus.MemWrite);
        end
    endtask

    task automatic test_partial_write();
        load_flags(4'b0011);
        drive(4'hE, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (bus.Flags !== 4'b1011) begin
            n_err++; $display("FAIL partial_nz: got %b expected 1011", bus.Flags);
        end
        drive(4'hE, 4'b0100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (bus.Flags !== 4'b1000) begin
            n_err++; $display("FAIL partial_cv: got %b expected 1000", bus.Flags);
        end
    endtask

    task automatic test_cond_table();
        logic [3:0]  tbl_flags [4];
        logic [15:0] tbl_exp   [4];
        logic [15:0] exp_vec;
        tbl_flags[0] = 4'b1000; tbl_exp[0] = 16'h6A9A;
        tbl_flags[1] = 4'b0110; tbl_exp[1] = 16'h66A5;
        tbl_flags[2] = 4'b0001; tbl_exp[2] = 16'h6A6A;
        tbl_flags[3] = 4'b1001; tbl_exp[3] = 16'h565A;
        for (int t = 0; t < 4; t++) begin
            load_flags(tbl_flags[t]);
            exp_vec = tbl_exp[t];
            exp_vec[15] = nv_exp;
            for (int c = 0; c < 16; c++) begin
                drive(c[3:0], 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                n_cmp++;
                if (bus.CondEx !== exp_vec[c] || bus.RegWrite !== exp_vec[c]) begin
                    n_err++;
                    $display("FAIL cond_table flags=%b cond=%h: got condex=%b regwrite=%b expected %b",
                             tbl_flags[t], c[3:0], bus.CondEx, bus.RegWrite, exp_vec[c]);
                end
            end
        end
        load_flags(4'b0010);
        drive(4'h8, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.CondEx !== 1'b1) begin
            n_err++; $display("FAIL hi_c_set: got %b expected 1", bus.CondEx);
        end
        drive(4'h9, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.CondEx !== 1'b0) begin
            n_err++; $display("FAIL ls_c_set: got %b expected 0", bus.CondEx);
        end
    endtask

    task automatic test_suppress();
        load_flags(4'b0000);
        drive(4'h0, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.PCSrc !== 1'b0 || bus.RegWrite !== 1'b0) begin
            n_err++; $display("FAIL failed_cond_gate: got pc=%b reg=%b expected 0 0", bus.PCSrc, bus.RegWrite);
        end
        tick();
        n_cmp++;
        if (bus.Flags !== 4'b0000) begin
            n_err++; $display("FAIL failed_cond_flags: got %b expected 0000", bus.Flags);
        end
        drive(4'hE, 4'b1010, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.PCSrc !== 1'b1 || bus.MemWrite !== 1'b1) begin
            n_err++; $display("FAIL nowrite_gate: got reg=%b pc=%b mem=%b expected 0 1 1",
                              bus.RegWrite, bus.PCSrc, bus.MemWrite);
        end
        tick();
        n_cmp++;
        if (bus.Flags !== 4'b1010) begin
            n_err++; $display("FAIL nowrite_flags: got %b expected 1010", bus.Flags);
        end
    endtask

    task automatic test_stall();
        load_flags(4'b0000);
        drive(4'hE, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (bus.RegWrite !== 1'b0 || bus.PCSrc !== 1'b0 || bus.MemWrite !== 1'b0 || bus.CondEx !== 1'b1) begin
                n_err++; $display("FAIL stall_gate cycle %0d: got reg=%b pc=%b mem=%b condex=%b expected 0 0 0 1",
                                  i, bus.RegWrite, bus.PCSrc, bus.MemWrite, bus.CondEx);
            end
            tick();
            n_cmp++;
            if (bus.Flags !== 4'b0000) begin
                n_err++; $display("FAIL stall_flags cycle %0d: got %b expected 0000", i, bus.Flags);
            end
        end
        drive(4'hE, 4'b0110, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++; $display("FAIL stall_release_gate: got %b expected 1", bus.RegWrite);
        end
        tick();
        n_cmp++;
        if (bus.Flags !== 4'b0110) begin
            n_err++; $display("FAIL stall_release_flags: got %b expected 0110", bus.Flags);
        end
    endtask

    task automatic test_nv();
        drive(4'hF, 4'b1001, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== nv_exp) begin
            n_err++; $display("FAIL nv_regwrite: got %b expected %b", bus.RegWrite, nv_exp);
        end
        tick();
        n_cmp++;
        if (bus.Flags !== (nv_exp ? 4'b1001 : 4'b0110)) begin
            n_err++; $display("FAIL nv_flags: got %b expected %b", bus.Flags, nv_exp ? 4'b1001 : 4'b0110);
        end
    endtask

    task automatic test_back_to_back();
        load_flags(4'b0000);
        drive(4'h0, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.CondEx !== 1'b0) begin
            n_err++; $display("FAIL own_result: got %b expected 0", bus.CondEx);
        end
        drive(4'hE, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(4'h0, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b1) begin
            n_err++; $display("FAIL b2b_sees_z: got %b expected 1", bus.RegWrite);
        end
        tick();
        drive(4'h0, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.RegWrite !== 1'b0 || bus.Flags !== 4'b0000) begin
            n_err++; $display("FAIL b2b_clears_z: got reg=%b flags=%b expected 0 0000", bus.RegWrite, bus.Flags);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
`ifdef COND_NV_AL_EN
        nv_exp = 1'b1;
`else
        nv_exp = 1'b0;
`endif
        rst = 1'b0;
        drive(4'hE, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_flag_load_eq();
        test_partial_write();
        test_cond_table();
        test_suppress();
        test_stall();
        test_nv();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
